rename_alloc_ctrl: RTL and testbench

Allocation scheduler sitting in front of the rename stage's RAT free list. Each cycle it grants an in-order prefix of up to `N` dispatching instructions, limited by the tracked count of free physical registers. It drives the free-list pop enables and stalls dispatch when registers run out. On a branch-mispredict squash it blocks allocation for a fixed recovery window while the RAT and free list restore from the retirement copy.

---
 rtl/rename_alloc_ctrl_pkg.sv | 21 ++
 rtl/rename_alloc_ctrl_prefix_alloc.sv | 31 +++
 rtl/rename_alloc_ctrl.sv | 123 ++++++++++++
 tb/tb_rename_alloc_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rename_alloc_ctrl_pkg.sv
// Shared types and default sizing for the rename allocation scheduler.
// Defaults give a 2-wide machine with 64 physical and 32 architectural registers.
package rename_alloc_ctrl_pkg;

   localparam int ALLOC_N          = 2;
   localparam int PHYS_REG_SZ_R10K = 64;
   localparam int ARCH_REG_SZ      = 32;
   localparam int FREE_CNT_WIDTH   = $clog2(PHYS_REG_SZ_R10K + 1);

   typedef enum logic [0:0] {
      ALLOC_RUN     = 1'b0,
      ALLOC_RECOVER = 1'b1
   } alloc_state_e;

   typedef struct packed {
      logic [ALLOC_N-1:0] grant;
      logic [ALLOC_N-1:0] pop_en;
      logic               stall;
   } rename_alloc_packet_t;

endpackage

// File: rtl/rename_alloc_ctrl_prefix_alloc.sv
// Combinational in-order prefix grant: slot i passes only if every earlier slot is valid
// and the running count of destination writers still fits in the free count.
module prefix_alloc
   import rename_alloc_ctrl_pkg::*;
#(
   parameter int N     = ALLOC_N,
   parameter int CNT_W = FREE_CNT_WIDTH
) (
   input  logic             enable,
   input  logic [N-1:0]     req_valid,
   input  logic [N-1:0]     req_has_dest,
   input  logic [CNT_W-1:0] free_count,
   output logic [N-1:0]     grant
);

   logic [CNT_W:0] need_s;
   logic           chain_s;

   // Walk the slots in order; once the chain breaks it stays broken.
   always_comb begin
      grant   = {N{1'b0}};
      need_s  = {(CNT_W+1){1'b0}};
      chain_s = enable;
      for (int i = 0; i < N; i++) begin
         need_s   = need_s + {{CNT_W{1'b0}}, req_has_dest[i]};
         chain_s  = chain_s & req_valid[i] & (need_s <= {1'b0, free_count});
         grant[i] = chain_s;
      end
   end

endmodule

// File: rtl/rename_alloc_ctrl.sv
// Rename allocation scheduler: prefix grants against the free-register count, pop enables,
// dispatch stall, and a fixed post-squash recovery window while the RAT restores.
module rename_alloc_ctrl
   import rename_alloc_ctrl_pkg::*;
#(
   parameter int   N              = ALLOC_N,
   parameter int   PHYS_REGS      = PHYS_REG_SZ_R10K,
   parameter int   ARCH_REGS      = ARCH_REG_SZ,
   parameter int   RECOVER_CYCLES = 2,
   localparam int  CNT_W          = $clog2(PHYS_REGS + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N-1:0]     req_valid,
   input  logic [N-1:0]     req_has_dest,
   input  logic [N-1:0]     retire_free,
   input  logic             squash,
   input  logic [CNT_W-1:0] squash_free_count,
   output logic [N-1:0]     grant,
   output logic [N-1:0]     pop_en,
   output logic             stall,
   output logic             recovering,
   output logic [CNT_W-1:0] free_count,
   output logic             err_overflow
);

   localparam int              RC_W        = $clog2(RECOVER_CYCLES + 1);
   localparam logic [CNT_W:0]  FREE_INIT_W = (CNT_W+1)'(PHYS_REGS - ARCH_REGS);
   localparam logic [RC_W-1:0] RC_LOAD     = RC_W'(RECOVER_CYCLES - 1);

   alloc_state_e   state_r, state_nxt_s;
   logic [RC_W-1:0] rcnt_r, rcnt_nxt_s;
   logic [CNT_W-1:0] free_count_r;
   logic            err_r;
   logic            alloc_en_s;
   logic [N-1:0]    grant_s;
   logic [N-1:0]    pop_en_s;
   logic [CNT_W:0]  pop_cnt_s, ret_cnt_s, next_cnt_s;
   logic            overflow_s;

   assign alloc_en_s = (state_r == ALLOC_RUN) && !squash;

   prefix_alloc #(
      .N     (N),
      .CNT_W (CNT_W)
   ) u_prefix_alloc (
      .enable       (alloc_en_s),
      .req_valid    (req_valid),
      .req_has_dest (req_has_dest),
      .free_count   (free_count_r),
      .grant        (grant_s)
   );

   assign pop_en_s     = grant_s & req_has_dest;
   assign grant        = grant_s;
   assign pop_en       = pop_en_s;
   assign stall        = |(req_valid & ~grant_s);
   assign recovering   = (state_r == ALLOC_RECOVER);
   assign free_count   = free_count_r;
   assign err_overflow = err_r;

   // Recovery FSM: a squash always (re)starts the window, otherwise count it down.
   always_comb begin
      state_nxt_s = state_r;
      rcnt_nxt_s  = rcnt_r;
      if (squash) begin
         state_nxt_s = ALLOC_RECOVER;
         rcnt_nxt_s  = RC_LOAD;
      end else begin
         case (state_r)
            ALLOC_RUN: begin
               state_nxt_s = ALLOC_RUN;
               rcnt_nxt_s  = {RC_W{1'b0}};
            end
            ALLOC_RECOVER: begin
               if (rcnt_r == {RC_W{1'b0}}) begin
                  state_nxt_s = ALLOC_RUN;
                  rcnt_nxt_s  = {RC_W{1'b0}};
               end else begin
                  state_nxt_s = ALLOC_RECOVER;
                  rcnt_nxt_s  = rcnt_r - RC_W'(1);
               end
            end
            default: begin
               state_nxt_s = ALLOC_RUN;
               rcnt_nxt_s  = {RC_W{1'b0}};
            end
         endcase
      end
   end

   // Next free count one bit wider so an over-return is visible before saturation.
   always_comb begin
      pop_cnt_s = {(CNT_W+1){1'b0}};
      ret_cnt_s = {(CNT_W+1){1'b0}};
      for (int i = 0; i < N; i++) begin
         pop_cnt_s = pop_cnt_s + {{CNT_W{1'b0}}, pop_en_s[i]};
         ret_cnt_s = ret_cnt_s + {{CNT_W{1'b0}}, retire_free[i]};
      end
      if (squash) begin
         next_cnt_s = {1'b0, squash_free_count};
      end else begin
         next_cnt_s = {1'b0, free_count_r} - pop_cnt_s + ret_cnt_s;
      end
      overflow_s = (next_cnt_s > FREE_INIT_W);
   end

   // State, recovery counter, free count and sticky overflow flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r      <= ALLOC_RUN;
         rcnt_r       <= {RC_W{1'b0}};
         free_count_r <= FREE_INIT_W[CNT_W-1:0];
         err_r        <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         rcnt_r       <= rcnt_nxt_s;
         free_count_r <= overflow_s ? FREE_INIT_W[CNT_W-1:0] : next_cnt_s[CNT_W-1:0];
         err_r        <= err_r | overflow_s;
      end
   end

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed bench for rename_alloc_ctrl with hand-computed expectations
// (N=2, 64 physical / 32 architectural registers, two recovery cycles).
module tb_rename_alloc_ctrl;

   localparam int N     = 2;
   localparam int CNT_W = 7;

   logic             clock;
   logic             reset;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_has_dest;
   logic [N-1:0]     retire_free;
   logic             squash;
   logic [CNT_W-1:0] squash_free_count;
   logic [N-1:0]     grant;
   logic [N-1:0]     pop_en;
   logic             stall;
   logic             recovering;
   logic [CNT_W-1:0] free_count;
   logic             err_overflow;

   int n_checks;
   int n_errors;

   rename_alloc_ctrl dut (
      .clock             (clock),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_has_dest      (req_has_dest),
      .retire_free       (retire_free),
      .squash            (squash),
      .squash_free_count (squash_free_count),
      .grant             (grant),
      .pop_en            (pop_en),
      .stall             (stall),
      .recovering        (recovering),
      .free_count        (free_count),
      .err_overflow      (err_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] d, input logic [1:0] r,
                        input logic sq, input logic [6:0] sfc);
      req_valid         = v;
      req_has_dest      = d;
      retire_free       = r;
      squash            = sq;
      squash_free_count = sfc;
      #1;
   endtask

   task automatic check_comb(input string tag, input logic [1:0] g, input logic [1:0] p,
                             input logic s);
      check_val({tag, "_grant"}, {30'd0, grant}, {30'd0, g});
      check_val({tag, "_pop"},   {30'd0, pop_en}, {30'd0, p});
      check_val({tag, "_stall"}, {31'd0, stall}, {31'd0, s});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      drive(2'b00, 2'b00, 2'b00, 1'b0, 7'd0);
      check_val("rst_free", {25'd0, free_count}, 32'd32);
      check_val("rst_err",  {31'd0, err_overflow}, 32'd0);
      check_val("rst_rec",  {31'd0, recovering}, 32'd0);
      check_comb("rst", 2'b00, 2'b00, 1'b0);
      reset = 1'b0;

      // Full list, both slots write a destination.
      tick();
      drive(2'b11, 2'b11, 2'b00, 1'b0, 7'd0);
      check_comb("full", 2'b11, 2'b11, 1'b0);
      tick();
      check_val("full_cnt", {25'd0, free_count}, 32'd30);

      // One pop, two frees: 30 - 1 + 2.
      drive(2'b11, 2'b01, 2'b11, 1'b0, 7'd0);
      check_comb("mix", 2'b11, 2'b01, 1'b0);
      tick();
      check_val("mix_cnt", {25'd0, free_count}, 32'd31);

      // Slot 0 invalid blocks the whole prefix.
      drive(2'b10, 2'b11, 2'b00, 1'b0, 7'd0);
      check_comb("hole", 2'b00, 2'b00, 1'b1);
      tick();
      check_val("hole_cnt", {25'd0, free_count}, 32'd31);

      // Squash to 20 with valid requests; two recovery cycles.
      drive(2'b11, 2'b11, 2'b00, 1'b1, 7'd20);
      check_comb("sq_t0", 2'b00, 2'b00, 1'b1);
      check_val("sq_t0_rec", {31'd0, recovering}, 32'd0);
      tick();
      drive(2'b11, 2'b11, 2'b00, 1'b0, 7'd0);
      check_val("sq_t1_rec", {31'd0, recovering}, 32'd1);
      check_val("sq_t1_cnt", {25'd0, free_count}, 32'd20);
      check_comb("sq_t1", 2'b00, 2'b00, 1'b1);
      tick();
      check_val("sq_t2_rec", {31'd0, recovering}, 32'd1);
      check_comb("sq_t2", 2'b00, 2'b00, 1'b1);
      tick();
      check_val("sq_t3_rec", {31'd0, recovering}, 32'd0);
      check_comb("sq_t3", 2'b11, 2'b11, 1'b0);
      tick();
      check_val("sq_t4_cnt", {25'd0, free_count}, 32'd18);

      // Squash to a count of 1, then one free register for two dest slots.
      drive(2'b00, 2'b00, 2'b00, 1'b1, 7'd1);
      tick();
      drive(2'b00, 2'b00, 2'b00, 1'b0, 7'd0);
      tick();
      tick();
      check_val("one_rec", {31'd0, recovering}, 32'd0);
      check_val("one_cnt", {25'd0, free_count}, 32'd1);
      drive(2'b11, 2'b11, 2'b00, 1'b0, 7'd0);
      check_comb("one", 2'b01, 2'b01, 1'b1);
      tick();
      check_val("one_next", {25'd0, free_count}, 32'd0);

      // Empty list: non-dest slot 0 passes, dest slot 1 stalls.
      drive(2'b11, 2'b10, 2'b00, 1'b0, 7'd0);
      check_comb("empty", 2'b01, 2'b00, 1'b1);
      tick();
      check_val("empty_cnt", {25'd0, free_count}, 32'd0);
      drive(2'b11, 2'b00, 2'b00, 1'b0, 7'd0);
      check_comb("empty_nodest", 2'b11, 2'b00, 1'b0);

      // Back-to-back squash extends the window by one cycle.
      drive(2'b11, 2'b00, 2'b00, 1'b1, 7'd10);
      check_comb("ext_t0", 2'b00, 2'b00, 1'b1);
      tick();
      drive(2'b11, 2'b00, 2'b00, 1'b1, 7'd12);
      check_val("ext_t1_cnt", {25'd0, free_count}, 32'd10);
      check_comb("ext_t1", 2'b00, 2'b00, 1'b1);
      tick();
      drive(2'b11, 2'b00, 2'b00, 1'b0, 7'd0);
      check_val("ext_t2_rec", {31'd0, recovering}, 32'd1);
      check_val("ext_t2_cnt", {25'd0, free_count}, 32'd12);
      tick();
      check_val("ext_t3_rec", {31'd0, recovering}, 32'd1);
      check_comb("ext_t3", 2'b00, 2'b00, 1'b1);
      tick();
      check_val("ext_t4_rec", {31'd0, recovering}, 32'd0);
      check_comb("ext_t4", 2'b11, 2'b00, 1'b0);

      // Restore a full list, then return one register too many.
      drive(2'b00, 2'b00, 2'b00, 1'b1, 7'd32);
      tick();
      drive(2'b00, 2'b00, 2'b00, 1'b0, 7'd0);
      tick();
      tick();
      check_val("ovf_pre_cnt", {25'd0, free_count}, 32'd32);
      check_val("ovf_pre_err", {31'd0, err_overflow}, 32'd0);
      drive(2'b00, 2'b00, 2'b01, 1'b0, 7'd0);
      tick();
      check_val("ovf_err", {31'd0, err_overflow}, 32'd1);
      check_val("ovf_cnt", {25'd0, free_count}, 32'd32);
      drive(2'b00, 2'b00, 2'b00, 1'b0, 7'd0);
      tick();
      check_val("ovf_sticky", {31'd0, err_overflow}, 32'd1);
      check_val("ovf_hold", {25'd0, free_count}, 32'd32);

      // Asynchronous reset in the middle of recovery.
      drive(2'b00, 2'b00, 2'b00, 1'b1, 7'd5);
      tick();
      drive(2'b00, 2'b00, 2'b00, 1'b0, 7'd0);
      check_val("arst_pre_rec", {31'd0, recovering}, 32'd1);
      check_val("arst_pre_cnt", {25'd0, free_count}, 32'd5);
      reset = 1'b1;
      #1;
      check_val("arst_rec", {31'd0, recovering}, 32'd0);
      check_val("arst_cnt", {25'd0, free_count}, 32'd32);
      check_val("arst_err", {31'd0, err_overflow}, 32'd0);
      reset = 1'b0;
      drive(2'b11, 2'b11, 2'b00, 1'b0, 7'd0);
      check_comb("arst_run", 2'b11, 2'b11, 1'b0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
